cmd_word_serializer: RTL and testbench

Parametrised successor to the single-entry command latch in the G-code interpreter test path. On each rising edge of `set_ready` it captures one command (`cmd`, `x_value`, `y_value`) into a DEPTH-entry FIFO. It then streams each entry to the downstream controller interface as WORD_W-bit words over a valid/ready handshake. It sits between the G-code parser and the motor-controller interface, decoupling parser bursts from controller consumption.

---
 rtl/gcode_ctrl_pkg.sv | 19 +
 rtl/cmd_fifo.sv | 59 +++++
 rtl/cmd_word_serializer.sv | 147 ++++++++++++++
 tb/tb_cmd_word_serializer.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/gcode_ctrl_pkg.sv
// rtl/gcode_ctrl_pkg.sv - shared types and helpers for the G-code command path
package gcode_ctrl_pkg;

    typedef enum logic [1:0] {
        FIELD_CMD = 2'd0,
        FIELD_X   = 2'd1,
        FIELD_Y   = 2'd2
    } field_t;

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } ser_state_t;

    function automatic int num_words(input int width, input int word_w);
        return (width + word_w - 1) / word_w;
    endfunction

endpackage

// File: rtl/cmd_fifo.sv
// rtl/cmd_fifo.sv - synchronous command FIFO with wrap-around pointers
module cmd_fifo #(
    parameter int WIDTH = 33,
    parameter int DEPTH = 4
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic                             push,
    input  logic [WIDTH-1:0]                 push_data,
    input  logic                             pop,
    output logic [WIDTH-1:0]                 pop_data,
    output logic                             full,
    output logic                             empty,
    output logic [$clog2(DEPTH+1)-1:0]       count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             wr_ok;
    logic             rd_ok;

    assign full     = (count == CW'(DEPTH));
    assign empty    = (count == '0);
    // a pop in the same cycle frees the slot, so a full FIFO can still take a write
    assign wr_ok    = push && (!full || pop);
    assign rd_ok    = pop && !empty;
    assign pop_data = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (wr_ok) begin
            mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_ok) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (rd_ok) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({wr_ok, rd_ok})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/cmd_word_serializer.sv
// rtl/cmd_word_serializer.sv - captures G-code commands and streams them as narrow words
module cmd_word_serializer
    import gcode_ctrl_pkg::*;
#(
    parameter int CMD_W   = 5,
    parameter int COORD_W = 14,
    parameter int WORD_W  = 4,
    parameter int DEPTH   = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       set_ready,
    input  logic [CMD_W-1:0]           cmd,
    input  logic [COORD_W-1:0]         x_value,
    input  logic [COORD_W-1:0]         y_value,
    output logic                       controller_ready,
    output logic                       overflow,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       word_valid,
    input  logic                       word_ready,
    output logic [WORD_W-1:0]          word_data,
    output logic [1:0]                 word_field,
    output logic                       word_last
);

    localparam int NC      = num_words(CMD_W, WORD_W);
    localparam int NX      = num_words(COORD_W, WORD_W);
    localparam int NW      = NC + 2 * NX;
    localparam int IW      = $clog2(NW);
    localparam int CP_W    = NC * WORD_W;
    localparam int XP_W    = NX * WORD_W;
    localparam int ENTRY_W = CMD_W + 2 * COORD_W;

    localparam logic [IW-1:0] X_START  = IW'(NC);
    localparam logic [IW-1:0] Y_START  = IW'(NC + NX);
    localparam logic [IW-1:0] LAST_IDX = IW'(NW - 1);

    logic               set_ready_prev;
    logic               capture;
    logic               push;
    logic               pop;
    logic               fifo_full;
    logic               fifo_empty;
    logic [ENTRY_W-1:0] entry_out;
    ser_state_t         state;
    logic [IW-1:0]      idx;
    logic [CP_W-1:0]    cmd_sr;
    logic [XP_W-1:0]    x_sr;
    logic [XP_W-1:0]    y_sr;
    field_t             cur_field;

    assign capture = set_ready && !set_ready_prev;
    assign pop     = (state == IDLE) && !fifo_empty;
    assign push    = capture && (!fifo_full || pop);

    cmd_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (push),
        .push_data ({cmd, x_value, y_value}),
        .pop       (pop),
        .pop_data  (entry_out),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (count)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            set_ready_prev   <= 1'b0;
            controller_ready <= 1'b0;
            overflow         <= 1'b0;
        end else begin
            set_ready_prev   <= set_ready;
            controller_ready <= push;
            if (capture && !push) begin
                overflow <= 1'b1;
            end
        end
    end

    always_comb begin
        cur_field = FIELD_Y;
        if (idx < X_START) begin
            cur_field = FIELD_CMD;
        end else if (idx < Y_START) begin
            cur_field = FIELD_X;
        end
    end

    // each field has its own shift register; only the field being sent shifts
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state  <= IDLE;
            idx    <= '0;
            cmd_sr <= '0;
            x_sr   <= '0;
            y_sr   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (!fifo_empty) begin
                        cmd_sr <= CP_W'(entry_out[ENTRY_W-1 -: CMD_W]);
                        x_sr   <= XP_W'(entry_out[2*COORD_W-1 -: COORD_W]);
                        y_sr   <= XP_W'(entry_out[COORD_W-1:0]);
                        idx    <= '0;
                        state  <= SEND;
                    end
                end
                SEND: begin
                    if (word_ready) begin
                        case (cur_field)
                            FIELD_CMD: cmd_sr <= cmd_sr >> WORD_W;
                            FIELD_X:   x_sr   <= x_sr >> WORD_W;
                            default:   y_sr   <= y_sr >> WORD_W;
                        endcase
                        if (idx == LAST_IDX) begin
                            state <= IDLE;
                        end else begin
                            idx <= idx + IW'(1);
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign word_valid = (state == SEND);
    assign word_field = word_valid ? cur_field : FIELD_CMD;
    assign word_last  = word_valid && (idx == LAST_IDX);

    always_comb begin
        word_data = '0;
        if (word_valid) begin
            case (cur_field)
                FIELD_CMD: word_data = cmd_sr[WORD_W-1:0];
                FIELD_X:   word_data = x_sr[WORD_W-1:0];
                default:   word_data = y_sr[WORD_W-1:0];
            endcase
        end
    end

endmodule

// File: tb/tb_cmd_word_serializer.sv
// tb/tb_cmd_word_serializer.sv - directed self-checking bench for cmd_word_serializer
module tb_cmd_word_serializer;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        set_ready = 1'b0;
    logic [4:0]  cmd = '0;
    logic [13:0] x_value = '0;
    logic [13:0] y_value = '0;
    logic        controller_ready;
    logic        overflow;
    logic [2:0]  count;
    logic        word_valid;
    logic        word_ready = 1'b1;
    logic [3:0]  word_data;
    logic [1:0]  word_field;
    logic        word_last;

    int checks = 0;
    int errors = 0;
    int cr_pulses = 0;
    int base;
    int vcount;
    logic [3:0] d;
    logic [1:0] f;

    logic [3:0]  hd [10] = '{4'h3, 4'h1, 4'hC, 4'h5, 4'hA, 4'h2, 4'h1, 4'h3, 4'hF, 4'h0};
    logic [1:0]  hf [10] = '{2'd0, 2'd0, 2'd1, 2'd1, 2'd1, 2'd1, 2'd2, 2'd2, 2'd2, 2'd2};
    logic [4:0]  ec [6]  = '{5'h01, 5'h02, 5'h1F, 5'h04, 5'h15, 5'h0A};
    logic [13:0] ex [6]  = '{14'h0123, 14'h3FFF, 14'h1000, 14'h0ABC, 14'h2222, 14'h0001};
    logic [13:0] ey [6]  = '{14'h3210, 14'h0000, 14'h0F0F, 14'h1357, 14'h3333, 14'h2468};

    cmd_word_serializer #(
        .CMD_W   (5),
        .COORD_W (14),
        .WORD_W  (4),
        .DEPTH   (4)
    ) dut (
        .clk              (clk),
        .reset            (reset),
        .set_ready        (set_ready),
        .cmd              (cmd),
        .x_value          (x_value),
        .y_value          (y_value),
        .controller_ready (controller_ready),
        .overflow         (overflow),
        .count            (count),
        .word_valid       (word_valid),
        .word_ready       (word_ready),
        .word_data        (word_data),
        .word_field       (word_field),
        .word_last        (word_last)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (controller_ready === 1'b1) cr_pulses++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic void exp_word(input logic [4:0] c, input logic [13:0] x, input logic [13:0] y,
                                     input int i, output logic [3:0] wd, output logic [1:0] wf);
        logic [7:0]  cv;
        logic [15:0] xv;
        logic [15:0] yv;
        cv = {3'b0, c};
        xv = {2'b0, x};
        yv = {2'b0, y};
        if (i < 2) begin
            wd = cv[4*i +: 4];
            wf = 2'd0;
        end else if (i < 6) begin
            wd = xv[4*(i-2) +: 4];
            wf = 2'd1;
        end else begin
            wd = yv[4*(i-6) +: 4];
            wf = 2'd2;
        end
    endfunction

    task automatic capture(input logic [4:0] c, input logic [13:0] x, input logic [13:0] y);
        cmd       = c;
        x_value   = x;
        y_value   = y;
        set_ready = 1'b1;
        @(negedge clk);
        set_ready = 1'b0;
    endtask

    task automatic pulse_reset();
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
    endtask

    task automatic recv_entry(input logic [4:0] c, input logic [13:0] x, input logic [13:0] y,
                              input int stall_idx, input int stall_len);
        int n;
        logic [3:0] ed;
        logic [1:0] ef;
        n = 0;
        while (!word_valid && n < 60) begin
            @(negedge clk);
            n++;
        end
        if (!word_valid) begin
            check("entry_timeout", 32'd0, 32'd1);
            return;
        end
        for (int i = 0; i < 10; i++) begin
            exp_word(c, x, y, i, ed, ef);
            if (i == stall_idx) begin
                word_ready = 1'b0;
                for (int j = 0; j < stall_len; j++) begin
                    @(negedge clk);
                    check("stall_valid", word_valid, 1);
                    check("stall_data", word_data, ed);
                    check("stall_field", word_field, ef);
                end
            end
            word_ready = 1'b1;
            check("word_data", word_data, ed);
            check("word_field", word_field, ef);
            check("word_last", word_last, (i == 9));
            @(negedge clk);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // reset state
        repeat (3) @(negedge clk);
        check("rst_valid", word_valid, 0);
        check("rst_data", word_data, 0);
        check("rst_field", word_field, 0);
        check("rst_last", word_last, 0);
        check("rst_count", count, 0);
        check("rst_overflow", overflow, 0);
        check("rst_cready", controller_ready, 0);
        reset = 1'b1;
        @(negedge clk);

        // single entry, hand-computed words
        base = cr_pulses;
        capture(5'h13, 14'h2A5C, 14'h0F31);
        check("cap_cready", controller_ready, 1);
        check("cap_count", count, 1);
        check("cap_valid", word_valid, 0);
        @(negedge clk);
        check("pop_valid", word_valid, 1);
        check("pop_cready", controller_ready, 0);
        check("pop_count", count, 0);
        for (int i = 0; i < 10; i++) begin
            check("t1_data", word_data, hd[i]);
            check("t1_field", word_field, hf[i]);
            check("t1_last", word_last, (i == 9));
            @(negedge clk);
        end
        check("t1_idle", word_valid, 0);
        check("t1_pulses", cr_pulses - base, 1);

        // backpressure in the middle of the x field
        capture(5'h13, 14'h2A5C, 14'h0F31);
        recv_entry(5'h13, 14'h2A5C, 14'h0F31, 3, 5);
        check("t2_idle", word_valid, 0);

        // overflow with the serializer stalled on entry 0
        pulse_reset();
        word_ready = 1'b0;
        base = cr_pulses;
        for (int i = 0; i < 6; i++) begin
            capture(ec[i], ex[i], ey[i]);
            @(negedge clk);
        end
        check("ovf_count", count, 4);
        check("ovf_flag", overflow, 1);
        check("ovf_pulses", cr_pulses - base, 5);
        for (int i = 0; i < 5; i++) begin
            recv_entry(ec[i], ex[i], ey[i], -1, 0);
        end
        check("ovf_drain_count", count, 0);
        check("ovf_sticky", overflow, 1);

        // capture while full in the same cycle as a pop
        pulse_reset();
        word_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            capture(ec[i], ex[i], ey[i]);
            @(negedge clk);
        end
        check("full_count", count, 4);
        recv_entry(ec[0], ex[0], ey[0], -1, 0);
        check("full_idle", word_valid, 0);
        capture(ec[5], ex[5], ey[5]);
        check("simul_count", count, 4);
        check("simul_overflow", overflow, 0);
        check("simul_cready", controller_ready, 1);
        check("simul_valid", word_valid, 1);
        for (int i = 1; i < 6; i++) begin
            recv_entry(ec[i], ex[i], ey[i], -1, 0);
        end
        check("simul_drain", count, 0);

        // set_ready held high yields one capture
        base = cr_pulses;
        cmd = 5'h0C; x_value = 14'h1ABC; y_value = 14'h0777;
        set_ready = 1'b1;
        recv_entry(5'h0C, 14'h1ABC, 14'h0777, -1, 0);
        set_ready = 1'b0;
        vcount = 0;
        repeat (15) begin
            @(negedge clk);
            if (word_valid) vcount++;
        end
        check("hold_extra_words", vcount, 0);
        check("hold_pulses", cr_pulses - base, 1);
        check("hold_count", count, 0);

        // reset during the third word with a queued entry
        pulse_reset();
        word_ready = 1'b0;
        capture(ec[0], ex[0], ey[0]);
        @(negedge clk);
        capture(ec[1], ex[1], ey[1]);
        check("mid_queued", count, 1);
        word_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        exp_word(ec[0], ex[0], ey[0], 2, d, f);
        check("mid_word2", word_data, d);
        check("mid_valid", word_valid, 1);
        reset = 1'b0;
        #1;
        check("async_valid", word_valid, 0);
        check("async_count", count, 0);
        @(negedge clk);
        reset = 1'b1;
        vcount = 0;
        repeat (15) begin
            @(negedge clk);
            if (word_valid) vcount++;
        end
        check("post_rst_words", vcount, 0);
        check("post_rst_count", count, 0);
        check("post_rst_overflow", overflow, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
